// File: rtl/ex_dispatch_queue_pkg.sv
// Shared types for the execute-stage dispatch queue:
// the buffered lane payload and the src2 operand select.
package ex_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_OP_W = 4;
  localparam int MEM_OP_W = 2;
  localparam int REG_W    = 5;

  typedef struct packed {
    logic [DEF_XLEN-1:0] src1;
    logic [DEF_XLEN-1:0] src2;
    logic [DEF_OP_W-1:0] op;
    logic                is_mem;
    logic [MEM_OP_W-1:0] mem_op;
    logic [REG_W-1:0]    rd;
    logic                rd_wen;
  } lane_payload_t;

  // Memory ops always take the immediate as the address offset.
  function automatic logic [DEF_XLEN-1:0] src2_sel(
    input logic                is_mem,
    input logic                use_imm,
    input logic [DEF_XLEN-1:0] rs2,
    input logic [DEF_XLEN-1:0] imm
  );
    return (is_mem || use_imm) ? imm : rs2;
  endfunction

endpackage

// File: rtl/ex_dispatch_queue_if.sv
// Issue/execute bus of the dispatch queue, all lanes
// flattened with lane i in bits [i*W +: W].
interface ex_dispatch_queue_if
  import ex_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int XLEN      = DEF_XLEN,
  parameter int OP_W      = DEF_OP_W,
  parameter int CNT_W     = 16
);

  logic [NUM_LANES-1:0]          in_valid;
  logic [NUM_LANES-1:0]          in_ready;
  logic [NUM_LANES*XLEN-1:0]     in_rs1;
  logic [NUM_LANES*XLEN-1:0]     in_rs2;
  logic [NUM_LANES*XLEN-1:0]     in_imm;
  logic [NUM_LANES-1:0]          in_use_imm;
  logic [NUM_LANES*OP_W-1:0]     in_op;
  logic [NUM_LANES-1:0]          in_is_mem;
  logic [NUM_LANES*MEM_OP_W-1:0] in_mem_op;
  logic [NUM_LANES*REG_W-1:0]    in_rd;
  logic [NUM_LANES-1:0]          in_rd_wen;

  logic [NUM_LANES-1:0]          out_valid;
  logic [NUM_LANES-1:0]          out_ready;
  logic [NUM_LANES*XLEN-1:0]     out_src1;
  logic [NUM_LANES*XLEN-1:0]     out_src2;
  logic [NUM_LANES*OP_W-1:0]     out_op;
  logic [NUM_LANES-1:0]          out_is_mem;
  logic [NUM_LANES*MEM_OP_W-1:0] out_mem_op;
  logic [NUM_LANES*REG_W-1:0]    out_rd;
  logic [NUM_LANES-1:0]          out_rd_wen;
  logic [NUM_LANES*CNT_W-1:0]    stall_cnt;

  modport master (
    output in_valid, in_rs1, in_rs2, in_imm, in_use_imm,
    output in_op, in_is_mem, in_mem_op, in_rd, in_rd_wen,
    input  in_ready,
    input  out_valid, out_src1, out_src2, out_op,
    input  out_is_mem, out_mem_op, out_rd, out_rd_wen,
    input  stall_cnt,
    output out_ready
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_imm, in_use_imm,
    input  in_op, in_is_mem, in_mem_op, in_rd, in_rd_wen,
    output in_ready,
    output out_valid, out_src1, out_src2, out_op,
    output out_is_mem, out_mem_op, out_rd, out_rd_wen,
    output stall_cnt,
    input  out_ready
  );

endinterface

// File: rtl/ex_dispatch_queue_lane_fifo.sv
// One lane of the dispatch queue: DEPTH-entry payload FIFO
// with flush and a saturating back-pressure counter.
module ex_lane_fifo
  import ex_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  lane_payload_t    push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output lane_payload_t    pop_data,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int AW = $clog2(DEPTH);

  lane_payload_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // Ready depends on occupancy only, never on pop_ready.
  assign push_ready = reset && (count < (AW+1)'(DEPTH));
  assign pop_valid  = (count != '0);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign pop_data   = pop_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        push && !pop: count <= count + (AW+1)'(1);
        pop && !push: count <= count - (AW+1)'(1);
        default:      count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (pop_valid && !pop_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ex_dispatch_queue.sv
// Execute-stage dispatch queue: per-lane operand forming
// feeding NUM_LANES independent buffered lanes.
module ex_dispatch_queue
  import ex_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int XLEN      = DEF_XLEN,
  parameter int OP_W      = DEF_OP_W,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16
) (
  input logic                clock,
  input logic                reset,
  input logic                flush,
  ex_dispatch_queue_if.slave bus
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_payload_t in_pl;
    lane_payload_t out_pl;
    logic          rdy;
    logic          vld;
    logic [CNT_W-1:0] stalls;

    assign in_pl = '{
      src1:   bus.in_rs1[i*XLEN +: XLEN],
      src2:   src2_sel(bus.in_is_mem[i],
                       bus.in_use_imm[i],
                       bus.in_rs2[i*XLEN +: XLEN],
                       bus.in_imm[i*XLEN +: XLEN]),
      op:     bus.in_op[i*OP_W +: OP_W],
      is_mem: bus.in_is_mem[i],
      mem_op: bus.in_mem_op[i*MEM_OP_W +: MEM_OP_W],
      rd:     bus.in_rd[i*REG_W +: REG_W],
      rd_wen: bus.in_rd_wen[i]
    };

    ex_lane_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .push_valid (bus.in_valid[i]),
      .push_ready (rdy),
      .push_data  (in_pl),
      .pop_valid  (vld),
      .pop_ready  (bus.out_ready[i]),
      .pop_data   (out_pl),
      .stall_cnt  (stalls)
    );

    assign bus.in_ready[i]  = rdy;
    assign bus.out_valid[i] = vld;
    assign bus.out_src1[i*XLEN +: XLEN] = out_pl.src1;
    assign bus.out_src2[i*XLEN +: XLEN] = out_pl.src2;
    assign bus.out_op[i*OP_W +: OP_W]   = out_pl.op;
    assign bus.out_is_mem[i]            = out_pl.is_mem;
    assign bus.out_mem_op[i*MEM_OP_W +: MEM_OP_W] = out_pl.mem_op;
    assign bus.out_rd[i*REG_W +: REG_W] = out_pl.rd;
    assign bus.out_rd_wen[i]            = out_pl.rd_wen;
    assign bus.stall_cnt[i*CNT_W +: CNT_W] = stalls;
  end

endmodule

// File: tb/tb_ex_dispatch_queue.sv
// Scoreboard bench for ex_dispatch_queue: directed beats,
// back-pressure, wrap, flush and mid-stream reset.
module tb_ex_dispatch_queue;
  import ex_pkg::*;

  localparam int NL = 2;
  localparam int XL = 32;
  localparam int OW = 4;
  localparam int CW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  always #5 clock = ~clock;

  ex_dispatch_queue_if #(
    .NUM_LANES (NL),
    .XLEN      (XL),
    .OP_W      (OW),
    .CNT_W     (CW)
  ) bus ();

  ex_dispatch_queue #(
    .NUM_LANES (NL),
    .XLEN      (XL),
    .OP_W      (OW),
    .DEPTH     (2),
    .CNT_W     (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  lane_payload_t sb0[$];
  lane_payload_t sb1[$];
  lane_payload_t pend [NL];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic lane_payload_t got(input int l);
    lane_payload_t g;
    g.src1   = bus.out_src1[l*XL +: XL];
    g.src2   = bus.out_src2[l*XL +: XL];
    g.op     = bus.out_op[l*OW +: OW];
    g.is_mem = bus.out_is_mem[l];
    g.mem_op = bus.out_mem_op[l*2 +: 2];
    g.rd     = bus.out_rd[l*5 +: 5];
    g.rd_wen = bus.out_rd_wen[l];
    return g;
  endfunction

  task automatic monitor();
    lane_payload_t e;
    lane_payload_t g;
    forever begin
      @(negedge clock);
      if (reset) begin
        for (int l = 0; l < NL; l++) begin
          if (bus.out_valid[l] && bus.out_ready[l]) begin
            g = got(l);
            checks++;
            if ((l == 0 && sb0.size() == 0) ||
                (l == 1 && sb1.size() == 0)) begin
              errors++;
              $display("FAIL sb_empty lane %0d got %h want none",
                       l, g);
            end else begin
              if (l == 0) e = sb0.pop_front();
              else        e = sb1.pop_front();
              if (g !== e) begin
                errors++;
                $display("FAIL sb_data lane %0d got %h want %h",
                         l, g, e);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic drive(input int l,
                       input logic [31:0] rs1,
                       input logic [31:0] rs2,
                       input logic [31:0] imm,
                       input logic use_imm,
                       input logic is_mem,
                       input logic [1:0] mem_op,
                       input logic [3:0] op,
                       input logic [4:0] rd,
                       input logic rd_wen,
                       input logic [31:0] exp_src2);
    bus.in_valid[l]          = 1'b1;
    bus.in_rs1[l*XL +: XL]   = rs1;
    bus.in_rs2[l*XL +: XL]   = rs2;
    bus.in_imm[l*XL +: XL]   = imm;
    bus.in_use_imm[l]        = use_imm;
    bus.in_is_mem[l]         = is_mem;
    bus.in_mem_op[l*2 +: 2]  = mem_op;
    bus.in_op[l*OW +: OW]    = op;
    bus.in_rd[l*5 +: 5]      = rd;
    bus.in_rd_wen[l]         = rd_wen;
    pend[l] = '{src1: rs1, src2: exp_src2, op: op,
                is_mem: is_mem, mem_op: mem_op,
                rd: rd, rd_wen: rd_wen};
  endtask

  task automatic tick();
    @(negedge clock);
    for (int l = 0; l < NL; l++) begin
      if (bus.in_valid[l] && bus.in_ready[l] && !flush && reset) begin
        if (l == 0) sb0.push_back(pend[l]);
        else        sb1.push_back(pend[l]);
      end
    end
    @(posedge clock);
    #1;
    if (flush || !reset) begin
      sb0.delete();
      sb1.delete();
    end
    bus.in_valid = '0;
    flush = 1'b0;
  endtask

  initial begin
    bus.in_valid   = '0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_imm     = '0;
    bus.in_use_imm = '0;
    bus.in_op      = '0;
    bus.in_is_mem  = '0;
    bus.in_mem_op  = '0;
    bus.in_rd      = '0;
    bus.in_rd_wen  = '0;
    bus.out_ready  = 2'b11;
    fork
      monitor();
    join_none

    tick();
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_stall", 64'(bus.stall_cnt), 0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'h3);

    drive(0, 32'h10, 32'h20, 32'h4, 0, 0, 2'd0, 4'h3, 5'd1, 1, 32'h20);
    tick();
    chk("t1_valid", 64'(bus.out_valid), 64'h1);
    chk("t1_src1", 64'(bus.out_src1[31:0]), 64'h10);
    chk("t1_src2", 64'(bus.out_src2[31:0]), 64'h20);
    tick();
    chk("t1_drain", 64'(bus.out_valid), 0);

    drive(1, 32'h11, 32'h55, 32'hFFFF_FFF0, 0, 1, 2'd2, 4'h1, 5'd2, 0,
          32'hFFFF_FFF0);
    drive(0, 32'h12, 32'h99, 32'h7, 1, 0, 2'd0, 4'h2, 5'd3, 1, 32'h7);
    tick();
    chk("t2_mem_src2", 64'(bus.out_src2[63:32]), 64'hFFFF_FFF0);
    chk("t2_mem_op", 64'(bus.out_mem_op[3:2]), 64'h2);
    chk("t2_imm_src2", 64'(bus.out_src2[31:0]), 64'h7);
    tick();

    bus.out_ready = 2'b00;
    drive(0, 32'hA0, 32'hA1, 32'hA2, 0, 0, 2'd0, 4'h4, 5'd4, 1, 32'hA1);
    tick();
    drive(0, 32'hB0, 32'hB1, 32'hB2, 1, 0, 2'd1, 4'h5, 5'd5, 1, 32'hB2);
    tick();
    chk("t3_full", 64'(bus.in_ready[0]), 0);
    drive(0, 32'hC0, 32'hC1, 32'hC2, 0, 0, 2'd0, 4'h6, 5'd6, 1, 32'hC1);
    tick();
    chk("t3_stall0_2", 64'(bus.stall_cnt[15:0]), 64'd2);
    chk("t3_stall1_0", 64'(bus.stall_cnt[31:16]), 0);
    tick();
    chk("t3_stall0_3", 64'(bus.stall_cnt[15:0]), 64'd3);
    bus.out_ready = 2'b01;
    #1;
    chk("t3_no_refill", 64'(bus.in_ready[0]), 0);
    tick();
    tick();
    tick();
    chk("t3_empty", 64'(bus.out_valid), 0);
    chk("t3_ready", 64'(bus.in_ready), 64'h3);
    bus.out_ready = 2'b11;

    drive(0, 32'h100, 32'h200, 32'h0, 0, 0, 2'd0, 4'h0, 5'd0, 1, 32'h200);
    tick();
    for (int k = 1; k <= 10; k++) begin
      drive(0, 32'h100 + k, 32'h200 + k, 32'h0, 0, 0, 2'd0,
            4'(k), 5'(k), 1, 32'h200 + k);
      tick();
      chk("t4_valid", 64'(bus.out_valid[0]), 64'h1);
    end
    tick();
    chk("t4_drain", 64'(bus.out_valid), 0);

    bus.out_ready = 2'b00;
    for (int k = 0; k < 2; k++) begin
      drive(0, 32'h300 + k, 32'h1, 32'h2, 0, 0, 2'd0, 4'h7, 5'd7, 1, 32'h1);
      drive(1, 32'h400 + k, 32'h3, 32'h4, 0, 1, 2'd3, 4'h8, 5'd8, 0, 32'h4);
      tick();
    end
    chk("t5_full", 64'(bus.in_ready), 0);
    chk("t5_stall", 64'(bus.stall_cnt), {32'd0, 16'd1, 16'd4});
    drive(0, 32'h500, 32'h1, 32'h2, 0, 0, 2'd0, 4'h9, 5'd9, 1, 32'h1);
    drive(1, 32'h600, 32'h1, 32'h2, 0, 0, 2'd0, 4'h9, 5'd9, 1, 32'h1);
    flush = 1'b1;
    bus.out_ready = 2'b11;
    tick();
    chk("t5_valid", 64'(bus.out_valid), 0);
    chk("t5_ready", 64'(bus.in_ready), 64'h3);
    chk("t5_stall_kept", 64'(bus.stall_cnt), {32'd0, 16'd1, 16'd4});
    drive(0, 32'h700, 32'h1, 32'h2, 0, 0, 2'd0, 4'hA, 5'd10, 1, 32'h1);
    flush = 1'b1;
    tick();
    chk("t5_push_drop", 64'(bus.out_valid), 0);

    bus.out_ready = 2'b00;
    drive(0, 32'h800, 32'h801, 32'h802, 0, 1, 2'd1, 4'hB, 5'd11, 1,
          32'h802);
    drive(1, 32'h900, 32'h901, 32'h902, 1, 0, 2'd2, 4'hC, 5'd12, 1,
          32'h902);
    tick();
    tick();
    chk("t6_stall", 64'(bus.stall_cnt), {32'd0, 16'd2, 16'd5});
    reset = 1'b0;
    drive(0, 32'hA00, 32'h1, 32'h2, 0, 0, 2'd0, 4'hD, 5'd13, 1, 32'h1);
    #1;
    chk("t6_rst_ready", 64'(bus.in_ready), 0);
    tick();
    chk("t6_rst_ready2", 64'(bus.in_ready), 0);
    chk("t6_valid", 64'(bus.out_valid), 0);
    chk("t6_src1", bus.out_src1, 0);
    chk("t6_src2", bus.out_src2, 0);
    chk("t6_ctl", 64'({bus.out_op, bus.out_is_mem, bus.out_mem_op,
                       bus.out_rd, bus.out_rd_wen}), 0);
    chk("t6_stall", 64'(bus.stall_cnt), 0);
    reset = 1'b1;
    #1;
    chk("t6_rel_ready", 64'(bus.in_ready), 64'h3);
    bus.out_ready = 2'b11;
    drive(1, 32'hB00, 32'hB01, 32'hB02, 0, 0, 2'd0, 4'hE, 5'd14, 1,
          32'hB01);
    tick();
    chk("t6_post_valid", 64'(bus.out_valid), 64'h2);
    tick();
    chk("t6_post_drain", 64'(bus.out_valid), 0);
    chk("sb_drained", 64'(sb0.size() + sb1.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
